// File: rtl/fwd_scoreboard.sv
// Decode-stage operand forwarding with a per-register scoreboard that tracks
// long-latency producers (mul/div, uncached loads) living outside the pipeline.
module fwd_scoreboard #(
   parameter int NUM_RD  = 2,
   parameter int NUM_STG = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_RD*ADDR_W-1:0]  rd_raddr,
   input  logic [NUM_STG-1:0]        stg_we,
   input  logic [NUM_STG-1:0]        stg_dvalid,
   input  logic [NUM_STG*ADDR_W-1:0] stg_waddr,
   input  logic [NUM_STG*DATA_W-1:0] stg_wdata,
   input  logic                      ll_issue,
   input  logic [ADDR_W-1:0]         ll_issue_waddr,
   input  logic                      ll_done,
   input  logic [ADDR_W-1:0]         ll_done_waddr,
   input  logic [DATA_W-1:0]         ll_done_wdata,
   output logic [NUM_RD-1:0]         rd_sel,
   output logic [NUM_RD*DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]         rd_stall,
   output logic                      stall,
   output logic                      sb_err,
   output logic [31:0]               stall_cycles
);

   localparam int NUM_REG = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0]  cnt_r       [NUM_REG];
   logic [CNT_W-1:0]  cnt_nxt_s   [NUM_REG];
   logic [NUM_REG-1:0] issue_hit_s;
   logic [NUM_REG-1:0] done_hit_s;
   logic              err_nxt_s;
   logic              sb_err_r;
   logic [31:0]       stall_cycles_r;

   logic [ADDR_W-1:0] raddr_s     [NUM_RD];
   logic [NUM_RD-1:0] hit_s;
   logic [NUM_RD-1:0] hit_valid_s;
   logic [DATA_W-1:0] hit_data_s  [NUM_RD];

   // Youngest matching pipeline stage per read port (descending scan, last hit wins)
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         raddr_s[i]     = rd_raddr[i*ADDR_W +: ADDR_W];
         hit_s[i]       = 1'b0;
         hit_valid_s[i] = 1'b0;
         hit_data_s[i]  = {DATA_W{1'b0}};
         for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (stg_we[s] && (stg_waddr[s*ADDR_W +: ADDR_W] == raddr_s[i])) begin
               hit_s[i]       = 1'b1;
               hit_valid_s[i] = stg_dvalid[s];
               hit_data_s[i]  = stg_wdata[s*DATA_W +: DATA_W];
            end else begin
               hit_s[i]       = hit_s[i];
            end
         end
      end
   end

   // Priority resolution: r0, pipeline stage, idle scoreboard, returning ll result, stall
   always_comb begin
      rd_sel   = {NUM_RD{1'b0}};
      rd_data  = {(NUM_RD*DATA_W){1'b0}};
      rd_stall = {NUM_RD{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         if (raddr_s[i] == {ADDR_W{1'b0}}) begin
            rd_sel[i]   = 1'b0;
         end else if (hit_s[i]) begin
            if (hit_valid_s[i]) begin
               rd_sel[i]                   = 1'b1;
               rd_data[i*DATA_W +: DATA_W] = hit_data_s[i];
            end else begin
               rd_stall[i] = 1'b1;
            end
         end else if (cnt_r[raddr_s[i]] == CNT_ZERO) begin
            rd_sel[i]   = 1'b0;
         end else if (ll_done && (ll_done_waddr == raddr_s[i]) &&
                      (cnt_r[raddr_s[i]] == CNT_ONE)) begin
            rd_sel[i]                   = 1'b1;
            rd_data[i*DATA_W +: DATA_W] = ll_done_wdata;
         end else begin
            rd_stall[i] = 1'b1;
         end
      end
   end

   assign stall = |rd_stall;

   // Scoreboard next state; same-register issue+done cancels, r0 is never tracked
   always_comb begin
      err_nxt_s = 1'b0;
      for (int r = 0; r < NUM_REG; r++) begin
         issue_hit_s[r] = ll_issue && (ll_issue_waddr == ADDR_W'(r)) && (r != 0);
         done_hit_s[r]  = ll_done  && (ll_done_waddr  == ADDR_W'(r)) && (r != 0);
         case ({issue_hit_s[r], done_hit_s[r]})
            2'b10: begin
               if (cnt_r[r] == CNT_MAX) begin
                  cnt_nxt_s[r] = cnt_r[r];
                  err_nxt_s    = 1'b1;
               end else begin
                  cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
               end
            end
            2'b01: begin
               if (cnt_r[r] == CNT_ZERO) begin
                  cnt_nxt_s[r] = cnt_r[r];
                  err_nxt_s    = 1'b1;
               end else begin
                  cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
               end
            end
            default: cnt_nxt_s[r] = cnt_r[r];
         endcase
      end
   end

   // Scoreboard counters, sticky error flag and saturating stall counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NUM_REG; r++) begin
            cnt_r[r] <= CNT_ZERO;
         end
         sb_err_r       <= 1'b0;
         stall_cycles_r <= 32'd0;
      end else begin
         for (int r = 0; r < NUM_REG; r++) begin
            cnt_r[r] <= cnt_nxt_s[r];
         end
         sb_err_r <= sb_err_r | err_nxt_s;
         if (stall && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign sb_err       = sb_err_r;
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a per-register outstanding-op model is
// compared every cycle, plus hand-computed literal checks along the way.
module tb_fwd_scoreboard;
   localparam int NUM_RD = 2, NUM_STG = 3, ADDR_W = 5, DATA_W = 32, CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        resetn;
   logic [9:0]  rd_raddr;
   logic [2:0]  stg_we, stg_dvalid;
   logic [14:0] stg_waddr;
   logic [95:0] stg_wdata;
   logic        ll_issue, ll_done;
   logic [4:0]  ll_issue_waddr, ll_done_waddr;
   logic [31:0] ll_done_wdata;
   logic [1:0]  rd_sel, rd_stall;
   logic [63:0] rd_data;
   logic        stall, sb_err;
   logic [31:0] stall_cycles;

   int          vectors = 0;
   int          miscompares = 0;
   int          cnt_m [32];
   logic        err_m;
   logic [31:0] stall_m;

   always #5 clk = ~clk;

   fwd_scoreboard #(.NUM_RD(NUM_RD), .NUM_STG(NUM_STG), .ADDR_W(ADDR_W),
                    .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .rd_raddr(rd_raddr), .stg_we(stg_we),
      .stg_dvalid(stg_dvalid), .stg_waddr(stg_waddr), .stg_wdata(stg_wdata),
      .ll_issue(ll_issue), .ll_issue_waddr(ll_issue_waddr), .ll_done(ll_done),
      .ll_done_waddr(ll_done_waddr), .ll_done_wdata(ll_done_wdata),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd_stall(rd_stall), .stall(stall),
      .sb_err(sb_err), .stall_cycles(stall_cycles));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outcome for one read address, straight from the priority rules
   function automatic void exp_port(input logic [4:0] ra, output logic sel,
                                    output logic [31:0] d, output logic st);
      logic found;
      sel = 1'b0; d = 32'd0; st = 1'b0;
      found = (ra == 5'd0);
      for (int s = 0; s < NUM_STG; s++) begin
         if (!found && stg_we[s] && stg_waddr[s*5 +: 5] == ra) begin
            found = 1'b1;
            if (stg_dvalid[s]) begin
               sel = 1'b1; d = stg_wdata[s*32 +: 32];
            end else begin
               st = 1'b1;
            end
         end
      end
      if (!found && cnt_m[ra] != 0) begin
         if (ll_done && ll_done_waddr == ra && cnt_m[ra] == 1) begin
            sel = 1'b1; d = ll_done_wdata;
         end else begin
            st = 1'b1;
         end
      end
   endfunction

   function automatic logic any_stall();
      logic s, st; logic [31:0] d;
      any_stall = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         exp_port(rd_raddr[i*5 +: 5], s, d, st);
         any_stall = any_stall | st;
      end
   endfunction

   // Model state: outstanding-op count per register, sticky error, stall count
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < 32; r++) cnt_m[r] <= 0;
         err_m   <= 1'b0;
         stall_m <= 32'd0;
      end else begin
         if (ll_issue && ll_issue_waddr != 5'd0 && !(ll_done && ll_done_waddr == ll_issue_waddr)) begin
            if (cnt_m[ll_issue_waddr] == CMAX) err_m <= 1'b1;
            else cnt_m[ll_issue_waddr] <= cnt_m[ll_issue_waddr] + 1;
         end
         if (ll_done && ll_done_waddr != 5'd0 && !(ll_issue && ll_issue_waddr == ll_done_waddr)) begin
            if (cnt_m[ll_done_waddr] == 0) err_m <= 1'b1;
            else cnt_m[ll_done_waddr] <= cnt_m[ll_done_waddr] - 1;
         end
         if (any_stall()) stall_m <= (stall_m == 32'hFFFF_FFFF) ? stall_m : stall_m + 32'd1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      rd_raddr = 10'd0; stg_we = 3'd0; stg_dvalid = 3'd0; stg_waddr = 15'd0;
      stg_wdata = 96'd0; ll_issue = 1'b0; ll_issue_waddr = 5'd0;
      ll_done = 1'b0; ll_done_waddr = 5'd0; ll_done_wdata = 32'd0;
   endtask

   initial begin
      resetn = 1'b1;
      clear();
      fork
         forever begin
            logic es, est; logic [31:0] ed; logic any;
            @(negedge clk);
            any = 1'b0;
            for (int i = 0; i < NUM_RD; i++) begin
               exp_port(rd_raddr[i*5 +: 5], es, ed, est);
               any = any | est;
               chk($sformatf("sel%0d", i), rd_sel[i], es);
               chk($sformatf("data%0d", i), rd_data[i*32 +: 32], ed);
               chk($sformatf("rd_stall%0d", i), rd_stall[i], est);
            end
            chk("stall", stall, any);
            chk("sb_err", sb_err, err_m);
            chk("stall_cycles", stall_cycles, stall_m);
         end
      join_none
      #2 resetn = 1'b0;
      #10 resetn = 1'b1;
      cyc();
      chk("L_rst_sb_err", sb_err, 1'b0);
      chk("L_rst_stall_cycles", stall_cycles, 32'd0);
      chk("L_rst_stall", stall, 1'b0);

      // all three stages match r5: stage 0 must win; port1 reads r0
      stg_we = 3'b111; stg_dvalid = 3'b111; stg_waddr = {5'd5, 5'd5, 5'd5};
      stg_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      rd_raddr = {5'd0, 5'd5};
      #1;
      chk("L_prio_sel", rd_sel, 2'b01);
      chk("L_prio_data0", rd_data[31:0], 32'hAAAA_0000);
      chk("L_prio_data1", rd_data[63:32], 32'd0);
      chk("L_prio_stall", rd_stall, 2'b00);
      cyc();
      stg_we = 3'b110; rd_raddr = {5'd5, 5'd5};
      #1;
      chk("L_prio_stage1", rd_data[63:32], 32'hBBBB_0001);

      // load-use: youngest match not ready, older ready one must be ignored
      cyc(); clear();
      stg_we = 3'b011; stg_dvalid = 3'b010; stg_waddr = {5'd0, 5'd8, 5'd8};
      stg_wdata = {32'd0, 32'h1111_1111, 32'h2222_2222}; rd_raddr = {5'd0, 5'd8};
      #1;
      chk("L_lu_rd_stall", rd_stall, 2'b01);
      chk("L_lu_stall", stall, 1'b1);
      chk("L_lu_sel", rd_sel, 2'b00);
      cyc(); cyc(); cyc(); clear();
      #1;
      chk("L_lu_stall_cycles", stall_cycles, 32'd3);

      // long latency single op on r9
      cyc();
      ll_issue = 1'b1; ll_issue_waddr = 5'd9; rd_raddr = {5'd0, 5'd9};
      #1 chk("L_ll_issue_cycle", stall, 1'b0);
      cyc(); ll_issue = 1'b0;
      #1 chk("L_ll_busy", stall, 1'b1);
      cyc(); ll_done = 1'b1; ll_done_waddr = 5'd9; ll_done_wdata = 32'h0000_1234;
      #1;
      chk("L_ll_fwd_sel", rd_sel, 2'b01);
      chk("L_ll_fwd_data", rd_data[31:0], 32'h0000_1234);
      chk("L_ll_fwd_stall", stall, 1'b0);
      cyc(); ll_done = 1'b0;
      #1;
      chk("L_ll_idle", stall, 1'b0);
      chk("L_ll_stall_cycles", stall_cycles, 32'd4);

      // two outstanding ops on r9: first return still stalls
      cyc(); ll_issue = 1'b1;
      cyc();
      cyc(); ll_issue = 1'b0; ll_done = 1'b1; ll_done_wdata = 32'h0000_5555;
      #1;
      chk("L_dbl_first_done", stall, 1'b1);
      chk("L_dbl_first_sel", rd_sel, 2'b00);
      cyc(); ll_done_wdata = 32'h0000_6666;
      #1;
      chk("L_dbl_second_data", rd_data[31:0], 32'h0000_6666);
      chk("L_dbl_second_stall", stall, 1'b0);
      cyc(); ll_done = 1'b0;

      // same-cycle issue and done on r9 with one outstanding
      cyc(); ll_issue = 1'b1;
      cyc(); ll_done = 1'b1; ll_done_wdata = 32'h0000_7777;
      #1 chk("L_sim_fwd", rd_data[31:0], 32'h0000_7777);
      cyc(); ll_issue = 1'b0; ll_done = 1'b0;
      #1;
      chk("L_sim_still_busy", stall, 1'b1);
      chk("L_sim_no_err", sb_err, 1'b0);
      cyc(); ll_done = 1'b1;
      cyc(); ll_done_waddr = 5'd10; rd_raddr = 10'd0;
      cyc(); ll_done = 1'b0;
      #1 chk("L_underflow_err", sb_err, 1'b1);

      // async reset in the middle of a stall with two ops outstanding on r9
      ll_issue = 1'b1; ll_issue_waddr = 5'd9; rd_raddr = {5'd0, 5'd9};
      cyc(); cyc(); ll_issue = 1'b0;
      #1 chk("L_pre_rst_stall", stall, 1'b1);
      cyc(); cyc();
      #1 resetn = 1'b0;
      #1;
      chk("L_mid_rst_sb_err", sb_err, 1'b0);
      chk("L_mid_rst_cycles", stall_cycles, 32'd0);
      chk("L_mid_rst_stall", stall, 1'b0);
      resetn = 1'b1;
      cyc();
      chk("L_post_rst_stall", stall, 1'b0);
      ll_done = 1'b1; ll_done_waddr = 5'd9;
      cyc(); ll_done = 1'b0;
      #1 chk("L_forgotten_done_err", sb_err, 1'b1);

      // register 0 is never tracked
      cyc(); resetn = 1'b0;
      #1 resetn = 1'b1;
      ll_issue = 1'b1; ll_issue_waddr = 5'd0; rd_raddr = 10'd0;
      cyc(); ll_issue = 1'b0; ll_done = 1'b1; ll_done_waddr = 5'd0;
      cyc(); ll_done = 1'b0;
      #1;
      chk("L_r0_no_err", sb_err, 1'b0);
      chk("L_r0_no_stall", stall, 1'b0);

      // overflow: fourth issue saturates at 3 and flags
      ll_issue = 1'b1; ll_issue_waddr = 5'd11; rd_raddr = {5'd0, 5'd11};
      cyc(); cyc(); cyc();
      #1 chk("L_ovf_three_ok", sb_err, 1'b0);
      cyc(); ll_issue = 1'b0;
      #1;
      chk("L_ovf_err", sb_err, 1'b1);
      chk("L_ovf_stall", stall, 1'b1);
      ll_done = 1'b1; ll_done_waddr = 5'd11;
      cyc(); cyc(); ll_done = 1'b0;
      #1 chk("L_ovf_one_left", stall, 1'b1);
      ll_done = 1'b1; ll_done_wdata = 32'h0BAD_CAFE;
      #1 chk("L_ovf_last_fwd", rd_data[31:0], 32'h0BAD_CAFE);
      cyc(); ll_done = 1'b0;
      #1 chk("L_ovf_drained", stall, 1'b0);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
